// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI4-Stream packet arbiter.
//   arb_state_t : arbiter FSM states
//   GRANT_W     : grant index width for the default build (4 sources)
//   BEAT_W      : beat counter width for the default build (400 beats)
//   width_for() : clog2 that never returns 0, for parameterised widths
//   bus_slice() : extracts slice idx of width w from a flattened bus
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int NUM_SRC_DEFAULT   = 4;
  localparam int MAX_BEATS_DEFAULT = 400;
  localparam int GRANT_W = $clog2(NUM_SRC_DEFAULT);
  localparam int BEAT_W  = $clog2(MAX_BEATS_DEFAULT);

  // Upper bounds for bus_slice: 8 sources of at most 1024 bits each.
  localparam int SLICE_MAX_W = 1024;
  localparam int SLICE_BUS_W = 8 * SLICE_MAX_W;

  function automatic int width_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Callers pass a constant idx, so this reduces to plain wiring.
  function automatic logic [SLICE_MAX_W-1:0] bus_slice(
    input logic [SLICE_BUS_W-1:0] bus,
    input int unsigned            idx,
    input int unsigned            w
  );
    return SLICE_MAX_W'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority picker.
//   req        : one request bit per source
//   last_grant : most recently served source
//   any_req    : at least one request is pending
//   pick       : first requester in the order last_grant+1, last_grant+2, ...
//                (modulo NUM_SRC); holds last_grant when nothing requests
module rr_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int GRANT_W = width_for(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               any_req,
  output logic [GRANT_W-1:0] pick
);

  logic [GRANT_W-1:0] idx;

  always_comb begin
    any_req = |req;
    pick    = last_grant;
    idx     = '0;
    // Scan from the farthest candidate to the nearest so the nearest
    // requester after last_grant overwrites everything else.
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = GRANT_W'((int'(last_grant) + k) % NUM_SRC);
      if (req[idx]) begin
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-granular round-robin arbiter that merges
// NUM_SRC AXI4-Stream sources onto one master stream.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : permits new grants (a packet in flight always completes)
//   err_clear           : pulse, clears err_overrun (a same-cycle set wins)
//   S_AXIS_*            : flattened source streams, source i in slice i
//   M_AXIS_*            : merged stream, combinational from the granted source
//   grant_id            : current or last granted source
//   busy                : high while a packet is being transferred
//   pkt_count           : completed packets, wraps at 2^32
//   err_overrun         : sticky per-source flag, packet cut at MAX_BEATS
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int AXIS_DATA_KEEP  = 32,
  parameter int MAX_BEATS       = 400
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 err_clear,
  input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [NUM_SRC*AXIS_DATA_KEEP-1:0]    S_AXIS_tkeep,
  input  logic [NUM_SRC-1:0]                   S_AXIS_tlast,
  input  logic [NUM_SRC-1:0]                   S_AXIS_tvalid,
  output logic [NUM_SRC-1:0]                   S_AXIS_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           M_AXIS_tdata,
  output logic [AXIS_DATA_KEEP-1:0]            M_AXIS_tkeep,
  output logic                                 M_AXIS_tlast,
  output logic                                 M_AXIS_tvalid,
  input  logic                                 M_AXIS_tready,
  output logic [width_for(NUM_SRC)-1:0]        grant_id,
  output logic                                 busy,
  output logic [31:0]                          pkt_count,
  output logic [NUM_SRC-1:0]                   err_overrun
);

  localparam int GW = width_for(NUM_SRC);
  localparam int BW = width_for(MAX_BEATS);

  arb_state_t         state_reg, state_next;
  logic [GW-1:0]      grant_reg, grant_next;
  logic [GW-1:0]      last_grant_reg, last_grant_next;
  logic [BW-1:0]      beat_cnt_reg, beat_cnt_next;
  logic [31:0]        pkt_count_reg, pkt_count_next;
  logic [NUM_SRC-1:0] err_reg, err_next;

  logic                       any_req;
  logic [GW-1:0]              pick;
  logic [AXIS_DATA_WIDTH-1:0] src_tdata [NUM_SRC];
  logic [AXIS_DATA_KEEP-1:0]  src_tkeep [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_tdata[gi] = AXIS_DATA_WIDTH'(bus_slice(SLICE_BUS_W'(S_AXIS_tdata), gi, AXIS_DATA_WIDTH));
    assign src_tkeep[gi] = AXIS_DATA_KEEP'(bus_slice(SLICE_BUS_W'(S_AXIS_tkeep), gi, AXIS_DATA_KEEP));
  end

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .GRANT_W (GW)
  ) u_picker (
    .req        (S_AXIS_tvalid),
    .last_grant (last_grant_reg),
    .any_req    (any_req),
    .pick       (pick)
  );

  logic sel_tvalid, sel_tlast, handshake, at_limit;

  assign sel_tvalid = S_AXIS_tvalid[grant_reg];
  assign sel_tlast  = S_AXIS_tlast[grant_reg];
  assign handshake  = (state_reg == XFER) && sel_tvalid && M_AXIS_tready;
  // The beat that would push the packet past MAX_BEATS closes it instead.
  assign at_limit   = (beat_cnt_reg == BW'(MAX_BEATS - 1));

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    pkt_count_next  = pkt_count_reg;
    err_next        = err_clear ? '0 : err_reg;
    S_AXIS_tready   = '0;
    M_AXIS_tdata    = '0;
    M_AXIS_tkeep    = '0;
    M_AXIS_tlast    = 1'b0;
    M_AXIS_tvalid   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (enable && any_req) begin
          state_next    = XFER;
          grant_next    = pick;
          beat_cnt_next = '0;
        end
      end
      XFER: begin
        M_AXIS_tdata             = src_tdata[grant_reg];
        M_AXIS_tkeep             = src_tkeep[grant_reg];
        M_AXIS_tvalid            = sel_tvalid;
        M_AXIS_tlast             = sel_tlast || at_limit;
        S_AXIS_tready[grant_reg] = M_AXIS_tready;
        if (handshake) begin
          beat_cnt_next = beat_cnt_reg + BW'(1);
          if (sel_tlast || at_limit) begin
            state_next      = IDLE;
            beat_cnt_next   = '0;
            last_grant_next = grant_reg;
            pkt_count_next  = pkt_count_reg + 32'd1;
            // Only a real cut is an overrun; a tlast landing exactly on
            // the limit is a legal maximum-length packet.
            if (at_limit && !sel_tlast) begin
              err_next[grant_reg] = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NUM_SRC - 1);
      beat_cnt_reg   <= '0;
      pkt_count_reg  <= '0;
      err_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      pkt_count_reg  <= pkt_count_next;
      err_reg        <= err_next;
    end
  end

  assign grant_id    = grant_reg;
  assign busy        = (state_reg == XFER);
  assign pkt_count   = pkt_count_reg;
  assign err_overrun = err_reg;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed testbench for axis_packet_arbiter: single source, round-robin
// fairness, backpressure, overrun cut, enable drop and mid-packet reset.
module tb_axis_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int KW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic            err_clear = 1'b0;
  logic [N*DW-1:0] S_AXIS_tdata = '0;
  logic [N*KW-1:0] S_AXIS_tkeep = '0;
  logic [N-1:0]    S_AXIS_tlast = '0;
  logic [N-1:0]    S_AXIS_tvalid = '0;
  logic [N-1:0]    S_AXIS_tready;
  logic [DW-1:0]   M_AXIS_tdata;
  logic [KW-1:0]   M_AXIS_tkeep;
  logic            M_AXIS_tlast;
  logic            M_AXIS_tvalid;
  logic            M_AXIS_tready = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic [31:0]     pkt_count;
  logic [N-1:0]    err_overrun;

  axis_packet_arbiter #(
    .NUM_SRC(N), .AXIS_DATA_WIDTH(DW), .AXIS_DATA_KEEP(KW), .MAX_BEATS(400)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clear(err_clear),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tkeep(S_AXIS_tkeep),
    .S_AXIS_tlast(S_AXIS_tlast), .S_AXIS_tvalid(S_AXIS_tvalid),
    .S_AXIS_tready(S_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tkeep(M_AXIS_tkeep),
    .M_AXIS_tlast(M_AXIS_tlast), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready),
    .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          src_pkts [N];
  int          src_len [N];
  int          src_pos [N];
  logic [31:0] src_seq [N];
  logic [31:0] exp_seq [N];
  logic        mready_cfg = 1'b1;
  logic        en_cfg = 1'b1;
  logic        rst_cfg = 1'b1;
  logic        clr_cfg = 1'b0;
  logic [N-1:0] hs_q = '0;
  int          cur_len = 0;
  int          grant_log [$];
  int          len_log [$];
  int          ord [6] = '{0, 1, 2, 3, 0, 1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      S_AXIS_tvalid[i]         = (src_pkts[i] > 0);
      S_AXIS_tlast[i]          = (src_pkts[i] > 0) && (src_pos[i] == src_len[i] - 1);
      S_AXIS_tdata[i*DW +: DW] = {216'b0, 8'(i), src_seq[i]};
      S_AXIS_tkeep[i*KW +: KW] = 32'hA5C3_0000 | 32'(i);
    end
  endtask

  task automatic start_src(input int i, input int pkts, input int len);
    src_pkts[i] = pkts;
    src_len[i]  = len;
    src_pos[i]  = 0;
    drive_sources();
  endtask

  // One clock: apply inputs after the edge, then check at the falling edge.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_q[i]) begin
        src_seq[i]++;
        if (src_pos[i] == src_len[i] - 1) begin
          src_pos[i] = 0;
          src_pkts[i]--;
        end else begin
          src_pos[i]++;
        end
      end
    end
    M_AXIS_tready = mready_cfg;
    enable        = en_cfg;
    rst           = rst_cfg;
    err_clear     = clr_cfg;
    drive_sources();
    @(negedge clk);
    hs_q    = S_AXIS_tvalid & S_AXIS_tready;
    exp_rdy = '0;
    if (busy) exp_rdy[grant_id] = M_AXIS_tready;
    chk("tready", 64'(S_AXIS_tready), 64'(exp_rdy));
    chk("tvalid", 64'(M_AXIS_tvalid), 64'(busy & S_AXIS_tvalid[grant_id]));
    if (M_AXIS_tvalid && M_AXIS_tready) begin
      chk("tdata", M_AXIS_tdata[63:0], {24'b0, 8'(grant_id), exp_seq[grant_id]});
      chk("tkeep", 64'(M_AXIS_tkeep), 64'(32'hA5C3_0000 | 32'(grant_id)));
      exp_seq[grant_id]++;
      cur_len++;
      if (M_AXIS_tlast) begin
        grant_log.push_back(int'(grant_id));
        len_log.push_back(cur_len);
        $display("pkt src=%0d len=%0d t=%0t", grant_id, cur_len, $time);
        cur_len = 0;
      end
    end
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      if (rnd) mready_cfg = 1'($urandom_range(0, 1));
      tick();
      n++;
      done = !busy;
      for (int i = 0; i < N; i++) if (src_pkts[i] != 0) done = 1'b0;
    end
    chk("drain_done", 64'(done), 64'd1);
    mready_cfg = 1'b1;
  endtask

  task automatic tick_until_len(input int len, input int budget);
    int n;
    n = 0;
    while (cur_len != len && n < budget) begin
      tick();
      n++;
    end
    chk("reach_beat", 64'(cur_len), 64'(len));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      src_pkts[i] = 0; src_len[i] = 1; src_pos[i] = 0;
      src_seq[i] = 32'd0; exp_seq[i] = 32'd0;
    end
    drive_sources();

    // Reset state
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mvalid", 64'(M_AXIS_tvalid), 64'd0);
    chk("rst_tready", 64'(S_AXIS_tready), 64'd0);
    chk("rst_count", 64'(pkt_count), 64'd0);
    chk("rst_err", 64'(err_overrun), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    rst_cfg = 1'b0;
    tick();

    // Single source 2, 4 beats
    start_src(2, 1, 4);
    tick();
    chk("t1_mvalid", 64'(M_AXIS_tvalid), 64'd1);
    chk("t1_grant", 64'(grant_id), 64'd2);
    chk("t1_first_tlast", 64'(M_AXIS_tlast), 64'd0);
    tick(); tick(); tick();
    chk("t1_tlast", 64'(M_AXIS_tlast), 64'd1);
    tick();
    chk("t1_idle_gap", 64'(busy), 64'd0);
    chk("t1_count", 64'(pkt_count), 64'd1);
    chk("t1_len", 64'(len_log[len_log.size()-1]), 64'd4);

    // Round-robin fairness from reset
    rst_cfg = 1'b1; tick(); rst_cfg = 1'b0; tick();
    grant_log.delete(); len_log.delete();
    for (int i = 0; i < N; i++) start_src(i, 2, 3);
    repeat (24) tick();
    chk("t2_count24", 64'(pkt_count), 64'd6);
    chk("t2_npkts", 64'(grant_log.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      chk("t2_order", 64'(grant_log[k]), 64'(ord[k]));
      chk("t2_len", 64'(len_log[k]), 64'd3);
    end
    wait_drain(40, 1'b0);
    chk("t2_count", 64'(pkt_count), 64'd8);

    // Backpressure with random tready
    grant_log.delete(); len_log.delete();
    start_src(0, 1, 10);
    start_src(3, 1, 10);
    wait_drain(200, 1'b1);
    chk("t3_npkts", 64'(grant_log.size()), 64'd2);
    chk("t3_first", 64'(grant_log[0]), 64'd0);
    chk("t3_second", 64'(grant_log[1]), 64'd3);
    chk("t3_len0", 64'(len_log[0]), 64'd10);
    chk("t3_len1", 64'(len_log[1]), 64'd10);
    chk("t3_count", 64'(pkt_count), 64'd10);

    // Overrun: 405-beat packet on source 1
    grant_log.delete(); len_log.delete();
    start_src(1, 1, 405);
    begin
      int n;
      n = 0;
      while (grant_log.size() == 0 && n < 600) begin
        tick();
        n++;
      end
    end
    chk("t4_cut_seen", 64'(grant_log.size()), 64'd1);
    chk("t4_cut_len", 64'(len_log[0]), 64'd400);
    tick();
    chk("t4_err_set", 64'(err_overrun), 64'b0010);
    chk("t4_count1", 64'(pkt_count), 64'd11);
    wait_drain(40, 1'b0);
    chk("t4_rest_src", 64'(grant_log[1]), 64'd1);
    chk("t4_rest_len", 64'(len_log[1]), 64'd5);
    chk("t4_err_hold", 64'(err_overrun), 64'b0010);
    chk("t4_count2", 64'(pkt_count), 64'd12);
    clr_cfg = 1'b1; tick(); clr_cfg = 1'b0; tick();
    chk("t4_err_clr", 64'(err_overrun), 64'd0);

    // Enable dropped at beat 2 of 5
    grant_log.delete(); len_log.delete();
    start_src(0, 1, 5);
    tick_until_len(2, 20);
    en_cfg = 1'b0;
    start_src(2, 1, 3);
    repeat (8) tick();
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_count", 64'(pkt_count), 64'd13);
    chk("t5_len", 64'(len_log[0]), 64'd5);
    chk("t5_no_grant", 64'(src_pkts[2]), 64'd1);
    chk("t5_npkts", 64'(grant_log.size()), 64'd1);
    en_cfg = 1'b1;
    wait_drain(20, 1'b0);
    chk("t5_resume_src", 64'(grant_log[1]), 64'd2);
    chk("t5_count2", 64'(pkt_count), 64'd14);

    // Reset asserted at beat 3
    grant_log.delete(); len_log.delete();
    start_src(3, 1, 6);
    tick_until_len(3, 20);
    rst_cfg = 1'b1; tick(); rst_cfg = 1'b0; tick();
    cur_len = 0;
    chk("t6_mvalid", 64'(M_AXIS_tvalid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_count", 64'(pkt_count), 64'd0);
    chk("t6_tready", 64'(S_AXIS_tready), 64'd0);
    chk("t6_grant_rst", 64'(grant_id), 64'd0);
    start_src(0, 1, 2);
    tick();
    chk("t6_regrant", 64'(grant_id), 64'd0);
    chk("t6_busy2", 64'(busy), 64'd1);
    wait_drain(30, 1'b0);
    chk("t6_npkts", 64'(grant_log.size()), 64'd2);
    chk("t6_next", 64'(grant_log[1]), 64'd3);
    chk("t6_rest_len", 64'(len_log[1]), 64'd2);
    chk("t6_count2", 64'(pkt_count), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

- Packet-granular round-robin arbiter that lets NUM_SRC AXI4-Stream producers share the single 256-bit S_AXIS_0 slave port of the PS DMA path.
- Instances of AXIS_data_generator or sensor channels connect on the slave side; the master side drives S_AXIS_0.
- A grant is held from the first beat through the tlast beat, so packets never interleave.
- Packets longer than MAX_BEATS are cut short and flagged. Software enables the block and reads its counters.

## Interface
Parameters:
- NUM_SRC, 4, number of requesting streams (2..8)
- AXIS_DATA_WIDTH, 256, tdata width per stream
- AXIS_DATA_KEEP, 32, tkeep width per stream (AXIS_DATA_WIDTH/8)
- MAX_BEATS, 400, maximum beats per packet before forced termination

Ports:
- clk  in  1  single clock (clk_50M domain); reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- enable  in  1  permits new grants; does not abort a packet in flight
- err_clear  in  1  one-cycle pulse, clears err_overrun
- S_AXIS_tdata  in  NUM_SRC*AXIS_DATA_WIDTH  source i occupies slice i
- S_AXIS_tkeep  in  NUM_SRC*AXIS_DATA_KEEP  per-source tkeep
- S_AXIS_tlast  in  NUM_SRC  per-source tlast
- S_AXIS_tvalid  in  NUM_SRC  per-source tvalid
- S_AXIS_tready  out  NUM_SRC  per-source tready
- M_AXIS_tdata  out  AXIS_DATA_WIDTH  to S_AXIS_0_tdata
- M_AXIS_tkeep  out  AXIS_DATA_KEEP  to S_AXIS_0_tkeep
- M_AXIS_tlast  out  1  to S_AXIS_0_tlast
- M_AXIS_tvalid  out  1  to S_AXIS_0_tvalid
- M_AXIS_tready  in  1  from S_AXIS_0_tready
- grant_id  out  clog2(NUM_SRC)  currently or last granted source
- busy  out  1  high in XFER
- pkt_count  out  32  completed packets, wraps at 2^32
- err_overrun  out  NUM_SRC  sticky, bit i set when source i's packet was force-terminated

## Operation
- FSM states:
  - IDLE: all S_AXIS_tready = 0 and M_AXIS_tvalid = 0. If enable is high and any S_AXIS_tvalid is high, select the first valid source in the order last_grant+1, last_grant+2, … (modulo NUM_SRC). Register it into grant_id, clear beat_cnt, and go to XFER.
  - XFER: the M_AXIS_* signals follow the granted source slice combinationally. S_AXIS_tready[grant_id] = M_AXIS_tready; every other tready is 0.
    - Each handshake (M_AXIS_tvalid & M_AXIS_tready) increments beat_cnt.
    - End of packet is a handshake where the source's tlast = 1, or where beat_cnt = MAX_BEATS-1 (forced).
    - At end of packet: set last_grant = grant_id, increment pkt_count, return to IDLE.
- Forced termination:
  - M_AXIS_tlast is driven to 1 on that beat and err_overrun[grant_id] is set.
  - The source's remaining beats form a new packet on a later grant.
- beat_cnt width is clog2(MAX_BEATS); it never exceeds MAX_BEATS-1.
- Source tvalid may drop mid-packet; the grant is held indefinitely with no timeout.
- Deasserting enable mid-packet: the packet completes normally, then the FSM stays in IDLE.
- err_clear clears err_overrun. If a set and a clear fall on the same cycle, the set wins for that bit.
- Reset values: state IDLE, grant_id 0, last_grant NUM_SRC-1 (so source 0 has first priority), beat_cnt 0, pkt_count 0, err_overrun 0, busy 0, all tready 0, M_AXIS_tvalid 0.
- Reset asserted mid-packet: on the next edge the FSM is IDLE and outputs are at reset values. The partial packet is abandoned; the downstream DMA must be reset by software.

## Timing
- Arbitration latency: 1 cycle. A tvalid seen in IDLE gives M_AXIS_tvalid in the following cycle.
- Data path is combinational in XFER (mux plus AND), with zero added latency. tready passes through combinationally from M to S.
- Between packets there is one IDLE cycle, so sustained throughput is L/(L+1) for L-beat packets.
- pkt_count, err_overrun and last_grant update on the edge that completes the last beat.
- grant_id is stable throughout XFER and only changes when entering XFER.

## Structure
- Package axis_arb_pkg holds:
  - the state enum {IDLE, XFER};
  - the localparams GRANT_W = clog2(NUM_SRC) and BEAT_W = clog2(MAX_BEATS);
  - a function that extracts slice i from the flattened tdata/tkeep buses.
- One sub-module, rr_picker: a combinational round-robin priority picker. Inputs are req[NUM_SRC] and last_grant; outputs are any_req and pick[GRANT_W]. It is reusable by future register/DMA-channel schedulers.

## Test plan
- Single source: source 2 only, 4-beat packet, M_AXIS_tready = 1 → grant_id = 2 and tvalid appears 1 cycle after request; 4 beats out with tlast on beat 4; pkt_count = 1; one IDLE cycle follows.
- Round-robin fairness: all 4 sources continuously valid with 3-beat packets → grant order 0,1,2,3,0,1 with no interleaving; pkt_count = 6 after 24 cycles.
- Backpressure: random M_AXIS_tready at 50% during 10-beat packets → data matches source beat-for-beat; non-granted tready stays 0 throughout.
- Overrun: source 1 sends 405 beats without tlast, MAX_BEATS = 400 → tlast forced on beat 400; err_overrun = 4'b0010; the remaining 5 beats arrive as a new packet; err_clear returns err_overrun to 0.
- Enable and reset:
  - enable dropped at beat 2 of 5 → packet completes and no further grant is issued.
  - rst asserted at beat 3 → next cycle tvalid = 0, pkt_count = 0, grant restarts at source 0.
